hazard_ctrl: RTL

Pipeline hazard controller for the five-stage CPU. Generates stall and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB segment registers. Covers three cases: load-use hazards that forwarding cannot cover, taken branches/jumps resolved in EX, and multi-cycle data-memory accesses driven by a req/ack handshake. Sits beside the forwarding unit. It owns the only sequential hazard state in the core: the memory-wait FSM, the wait counter, the timeout flag and the optional performance counters.

---
 rtl/hazard_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the five-stage pipeline.
// Covers load-use bubbles, taken-branch flushes resolved in EX and
// multi-cycle data-memory freezes (req/ack handshake with wait FSM).
// Optional feature macro: HAZARD_PERF_CNT_EN builds the performance
// counters; without it stall_cnt/flush_cnt/lu_cnt are tied to zero.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rf_re0_id,
    input  logic        rf_re1_id,
    input  logic [4:0]  rf_ra0_id,
    input  logic [4:0]  rf_ra1_id,
    input  logic        rf_we_ex,
    input  logic [4:0]  rf_wa_ex,
    input  logic        mem_re_ex,
    input  logic        br_taken_ex,
    input  logic        dmem_req_mem,
    input  logic        dmem_ack,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        stall_id_ex,
    output logic        stall_ex_mem,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_mem_wb,
    output logic        mem_busy,
    output logic        mem_timeout,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] lu_cnt
);

    localparam logic [0:0]  ST_RUN      = 1'b0;
    localparam logic [0:0]  ST_MEM_WAIT = 1'b1;
    localparam logic [15:0] TIMEOUT_W   = 16'(TIMEOUT);

    logic [0:0]  state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;

    logic load_use;
    logic freeze;
    logic lu_applied;

    // Hazard detection: a load in EX feeding a register read in ID, and a
    // memory access that has not completed this cycle.
    always_comb begin
        load_use = mem_re_ex & rf_we_ex & (rf_wa_ex != 5'd0) &
                   ((rf_re0_id & (rf_ra0_id == rf_wa_ex)) |
                    (rf_re1_id & (rf_ra1_id == rf_wa_ex)));
        freeze   = dmem_req_mem & ~dmem_ack;
    end

    // Prioritised stall/flush decode: freeze beats branch beats load-use.
    // A branch under freeze is deferred because EX is held and the branch
    // re-presents itself in the first unfrozen cycle.
    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_mem_wb = 1'b0;
        lu_applied   = 1'b0;
        if (freeze) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
        end else if (br_taken_ex) begin
            // The ID instruction is wrong-path, so its load-use is moot.
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
            lu_applied  = 1'b1;
        end
    end

    // Memory-wait FSM, wait counter and sticky timeout flag next-state.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            ST_RUN: begin
                if (freeze) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 16'd1;
                end else begin
                    wait_cnt_d = 16'd0;
                end
            end
            ST_MEM_WAIT: begin
                if (wait_cnt_q == TIMEOUT_W) begin
                    mem_timeout_d = 1'b1;
                end
                if (dmem_ack) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = 16'd0;
                end else if (wait_cnt_q != TIMEOUT_W) begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = 16'd0;
            end
        endcase
    end

    // Hazard state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= 16'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_busy    = (state_q == ST_MEM_WAIT);
    assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] lu_cnt_q,    lu_cnt_d;

    // Event counters; wrap naturally modulo 2^32.
    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall_pc};
        flush_cnt_d = flush_cnt_q + {31'd0, flush_if_id};
        lu_cnt_d    = lu_cnt_q    + {31'd0, lu_applied};
    end

    // Counter registers cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
            lu_cnt_q    <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            lu_cnt_q    <= lu_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign lu_cnt    = lu_cnt_q;
`else
    logic unused_lu;
    assign unused_lu = lu_applied;
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
    assign lu_cnt    = 32'd0;
`endif

endmodule
